instr_fetch_decode: RTL and testbench

- Front end of the RISC core and the reading side of the instruction ROM.
- Owns the PC, drives the ROM address and captures the returned word.
- Splits each word into the fixed Beta fields (opcode, rc, ra, rb, literal) and flags illegal opcodes.
- Delivers decoded instructions through a 2-entry buffer with a valid/ready handshake to the execute stage; accepts branch/jump redirects and exception vectoring.

---
 rtl/instr_fetch_decode_pkg.sv | 66 ++++++
 rtl/instr_skid_buf.sv | 77 +++++++
 rtl/instr_fetch_decode.sv | 85 ++++++++
 tb/tb_instr_fetch_decode.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// rtl/instr_fetch_decode_pkg.sv - Beta opcode constants, field layout, decoded entry type, legality check
package instr_fetch_decode_pkg;

  localparam logic [31:0] DEF_RESET_ADDR = 32'd0;
  localparam logic [31:0] DEF_ILLOP_ADDR = 32'd4;
  localparam logic [31:0] DEF_XADR_ADDR  = 32'd8;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RC_MSB  = 25;
  localparam int RC_LSB  = 21;
  localparam int RA_MSB  = 20;
  localparam int RA_LSB  = 16;
  localparam int RB_MSB  = 15;
  localparam int RB_LSB  = 11;
  localparam int LIT_MSB = 15;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] lit;
    logic        illop;
  } dec_entry_t;

  // ALU (0x20-0x2E) and ALU-constant (0x30-0x3E) classes leave every xx111 slot unassigned.
  function automatic logic is_legal_opcode(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR: ok = 1'b1;
      default: ok = op[5] && (op[2:0] != 3'b111);
    endcase
    return ok;
  endfunction

  function automatic dec_entry_t decode(input logic [31:0] pc, input logic [31:0] instr);
    dec_entry_t e;
    e.pc     = pc;
    e.instr  = instr;
    e.opcode = instr[OPC_MSB:OPC_LSB];
    e.rc     = instr[RC_MSB:RC_LSB];
    e.ra     = instr[RA_MSB:RA_LSB];
    e.rb     = instr[RB_MSB:RB_LSB];
    e.lit    = {{16{instr[LIT_MSB]}}, instr[LIT_MSB:0]};
    e.illop  = ~is_legal_opcode(instr[OPC_MSB:OPC_LSB]);
    return e;
  endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// rtl/instr_skid_buf.sv - 2-entry valid/ready buffer with flush; ready depends only on registered state
module instr_skid_buf
  import instr_fetch_decode_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_in_tvalid,
  input  logic [W-1:0] i_in_tdata,
  output logic         o_in_tready,
  output logic         o_out_tvalid,
  input  logic         i_out_tready,
  output logic [W-1:0] o_out_tdata
);

  localparam logic [1:0] LP_CAP = 2'(DEPTH);

  buf_state_e r_state;
  buf_state_e w_next_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic w_push;
  logic w_pop;

  assign o_in_tready  = (2'(r_state) < LP_CAP);
  assign o_out_tvalid = (r_state != BUF_EMPTY);
  assign o_out_tdata  = o_out_tvalid ? r_head : '0;
  assign w_push       = i_in_tvalid & o_in_tready;
  assign w_pop        = o_out_tvalid & i_out_tready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_flush) begin
      w_next_state = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: if (w_push) w_next_state = BUF_ONE;
        BUF_ONE: begin
          if (w_push && !w_pop) w_next_state = BUF_FULL;
          else if (!w_push && w_pop) w_next_state = BUF_EMPTY;
        end
        BUF_FULL: if (w_pop) w_next_state = BUF_ONE;
        default: w_next_state = BUF_EMPTY;
      endcase
    end
  end

  // Head is always r_head; the tail slot only ever shifts forward on a pop from FULL.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        BUF_EMPTY: if (w_push) r_head <= i_in_tdata;
        BUF_ONE: begin
          if (w_push && w_pop) r_head <= i_in_tdata;
          else if (w_push) r_tail <= i_in_tdata;
        end
        BUF_FULL: if (w_pop) r_head <= r_tail;
        default: r_head <= r_head;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - PC owner, ROM fetch, Beta field decode and 2-entry delivery buffer
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
  parameter logic [31:0] ILLOP_ADDR = DEF_ILLOP_ADDR,
  parameter logic [31:0] XADR_ADDR  = DEF_XADR_ADDR,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        exc_illop,
  input  logic        exc_irq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] out_instr,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rc,
  output logic [4:0]  out_ra,
  output logic [4:0]  out_rb,
  output logic [31:0] out_lit,
  output logic        out_illop
);

  logic [31:0] r_pc;
  logic        w_flush;
  logic        w_fetch;
  logic        w_buf_ready;
  logic        w_buf_valid;
  dec_entry_t  w_push_entry;
  dec_entry_t  w_head;

  assign imem_addr    = r_pc;
  assign w_flush      = exc_illop | exc_irq | redirect_valid;
  assign w_fetch      = w_buf_ready & ~w_flush;
  assign w_push_entry = decode(r_pc, imem_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_ADDR;
    end else if (exc_illop) begin
      r_pc <= ILLOP_ADDR;
    end else if (exc_irq) begin
      r_pc <= XADR_ADDR;
    end else if (redirect_valid) begin
      r_pc <= {redirect_addr[31:2], 2'b00};
    end else if (w_fetch) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // A pop coinciding with a flush is discarded along with the rest of the buffer.
  instr_skid_buf #(
    .W     ($bits(dec_entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (w_flush),
    .i_in_tvalid  (~w_flush),
    .i_in_tdata   (w_push_entry),
    .o_in_tready  (w_buf_ready),
    .o_out_tvalid (w_buf_valid),
    .i_out_tready (out_ready & ~w_flush),
    .o_out_tdata  (w_head)
  );

  assign out_valid  = w_buf_valid;
  assign out_pc     = w_head.pc;
  assign out_pc4    = w_buf_valid ? (w_head.pc + 32'd4) : 32'd0;
  assign out_instr  = w_head.instr;
  assign out_opcode = w_head.opcode;
  assign out_rc     = w_head.rc;
  assign out_ra     = w_head.ra;
  assign out_rb     = w_head.rb;
  assign out_lit    = w_head.lit;
  assign out_illop  = w_head.illop;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - directed bench with queue-based reference model of the fetch front end
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        exc_illop;
  logic        exc_irq;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rc;
  logic [4:0]  out_ra;
  logic [4:0]  out_rb;
  logic [31:0] out_lit;
  logic        out_illop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_decode dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .exc_illop      (exc_illop),
    .exc_irq        (exc_irq),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .out_instr      (out_instr),
    .out_opcode     (out_opcode),
    .out_rc         (out_rc),
    .out_ra         (out_ra),
    .out_rb         (out_rb),
    .out_lit        (out_lit),
    .out_illop      (out_illop)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0)  return 32'h80A41800;
    if (a == 32'hA0) return 32'h7FE0FFFF;
    if (a == 32'hA4) return 32'h00000000;
    if (a == 32'hA8) return 32'hC0A4FFFE;
    if (a == 32'hB0) return 32'h9C000000;
    return {(a[2] ? 6'h30 : 6'h20), a[6:2], a[11:7], a[8:4], a[15:5]};
  endfunction

  assign imem_data = rom_word(imem_addr);

  function automatic bit legal_op(input int op);
    return op inside {'h18, 'h19, 'h1B, 'h1C, 'h1D, 'h1F,
                      ['h20:'h26], ['h28:'h2E], ['h30:'h36], ['h38:'h3E]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mpc;
  bit          live = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        mpc  = 32'd0;
        live = 1;
      end else if (exc_illop) begin
        mq.delete();
        mpc = 32'd4;
      end else if (exc_irq) begin
        mq.delete();
        mpc = 32'd8;
      end else if (redirect_valid) begin
        mq.delete();
        mpc = redirect_addr & 32'hFFFF_FFFC;
      end else begin
        bit room;
        ment_t e;
        room = (mq.size() < 2);
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (room) begin
          e.pc = mpc;
          e.w  = rom_word(mpc);
          mq.push_back(e);
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        logic [31:0] w;
        check("imem_addr", imem_addr, mpc);
        check("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
        if (mq.size() > 0) begin
          w = mq[0].w;
          check("out_pc",     out_pc, mq[0].pc);
          check("out_pc4",    out_pc4, mq[0].pc + 32'd4);
          check("out_instr",  out_instr, w);
          check("out_opcode", {26'd0, out_opcode}, (w >> 26));
          check("out_rc",     {27'd0, out_rc}, (w >> 21) & 32'h1F);
          check("out_ra",     {27'd0, out_ra}, (w >> 16) & 32'h1F);
          check("out_rb",     {27'd0, out_rb}, (w >> 11) & 32'h1F);
          check("out_lit",    out_lit, 32'($signed(w[15:0])));
          check("out_illop",  {31'd0, out_illop}, {31'd0, !legal_op(int'(w >> 26))});
        end else begin
          check("idle_pc",    out_pc | out_pc4 | out_instr | out_lit, 32'd0);
          check("idle_flds",  {16'd0, out_opcode, out_rc, out_illop}, 32'd0);
          check("idle_rarb",  {22'd0, out_ra, out_rb}, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [11:0] pat;
    pat            = 12'b1011_0011_1010;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 32'd0;
    exc_illop      = 1'b0;
    exc_irq        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_addr",  imem_addr, 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    check("t1_valid",  {31'd0, out_valid}, 32'd1);
    check("t1_pc0",    out_pc, 32'd0);
    check("t1_opcode", {26'd0, out_opcode}, 32'h20);
    check("t1_rc",     {27'd0, out_rc}, 32'd5);
    check("t1_ra",     {27'd0, out_ra}, 32'd4);
    check("t1_rb",     {27'd0, out_rb}, 32'd3);
    @(negedge clk);
    check("t1_pc4", out_pc, 32'd4);
    @(negedge clk);
    check("t1_pc8", out_pc, 32'd8);

    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("t2_head", out_pc, 32'd8);
    check("t2_addr", imem_addr, 32'd16);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_addr  = 32'hA3;
    out_ready      = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t3_addr",  imem_addr, 32'hA0);
    check("t3_flush", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_pc",    out_pc, 32'hA0);
    check("t5_lit",   out_lit, 32'hFFFF_FFFF);
    check("t5_ldr",   {31'd0, out_illop}, 32'd0);
    @(negedge clk);
    check("t5_zero_illop", {31'd0, out_illop}, 32'd1);
    repeat (4) @(negedge clk);

    exc_illop      = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    @(negedge clk);
    exc_illop      = 1'b0;
    redirect_valid = 1'b0;
    check("t4_addr", imem_addr, 32'd4);
    @(negedge clk);
    check("t4_pc", out_pc, 32'd4);
    exc_irq = 1'b1;
    @(negedge clk);
    exc_irq = 1'b0;
    check("irq_addr", imem_addr, 32'd8);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      out_ready = pat[i];
      @(negedge clk);
    end

    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_addr",  imem_addr, 32'd0);
    repeat (2) @(negedge clk);

    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFA;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_a2",   imem_addr, 32'd0);
    check("wrap_head", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc4",  out_pc4, 32'd0);
    @(negedge clk);
    check("wrap_pc0", out_pc, 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
